mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single word-wide memory-controller request port between three requesters:
//   instruction fetch (IF), data load (LD) and data store (ST).
//   Sits between the fetch/LSU front ends and the byte-serial memory controller.
//   Policy: data ports have priority over IF. LD and ST alternate. An anti-starvation counter
//   forces an IF grant. One transaction is outstanding at a time; addr/data are latched at grant.
// PARAMETERS
//   STARVE_LIMIT  4  consecutive data grants with IF pending before IF is forced (1..15)
// PORTS
//   clk_in      in   1   system clock
//   rst_n_in    in   1   asynchronous, active-low reset
//   rdy_in      in   1   global ready; low = freeze all state, outputs hold
//   flush_in    in   1   pipeline flush pulse; discards a granted/pending IF response
//   if_valid    in   1   IF request, level; held until if_done or flush
//   if_addr     in   32  IF word address
//   if_done     out  1   1-cycle pulse: IF result valid on rd_data
//   ld_valid    in   1   load request, level; held until ld_done
//   ld_addr     in   32  load word address
//   ld_done     out  1   1-cycle pulse: load result valid on rd_data
//   st_valid    in   1   store request, level; held until st_done
//   st_addr     in   32  store word address
//   st_data     in   32  store data
//   st_done     out  1   1-cycle pulse: store written
//   rd_data     out  32  registered result of the last read transaction
//   mc_valid    out  1   request to memory controller
//   mc_addr     out  32  latched address
//   mc_wdata    out  32  latched store data (0 for reads)
//   mc_wr       out  1   1 = write
//   mc_ready    in   1   controller completion; sampled only in BUSY
//   mc_res      in   32  controller read data, valid with mc_ready
// BEHAVIOUR
//   - Reset (async, rst_n_in=0): state=IDLE; all outputs 0; starve_cnt=0; last_data=ST, so LD wins first.
//   - States: IDLE -> BUSY -> RESP -> IDLE. Every transition also requires rdy_in=1.
//   - IDLE, arbitration over the valids sampled this cycle:
//       1. IF, if if_valid && starve_cnt==STARVE_LIMIT;
//       2. otherwise LD/ST: if only one is pending it wins; if both are pending, the one
//          opposite to last_data wins;
//       3. otherwise IF, if if_valid.
//     If a request wins, the next edge latches owner, mc_addr, mc_wdata and mc_wr, sets mc_valid=1
//     and moves to BUSY. Request-to-mc_valid latency is 1 cycle.
//     An IF request with flush_in=1 in the same cycle is not granted.
//   - starve_cnt:
//       - data grant with if_valid=1: +1, saturating at STARVE_LIMIT;
//       - IF grant, or if_valid=0 in IDLE: cleared to 0.
//   - BUSY: mc_valid stays 1 and mc_* stay stable. On mc_ready=1 the next edge does:
//     rd_data<=mc_res for reads (unchanged for ST), mc_valid<=0, state<=RESP.
//   - RESP: the owner's *_done is 1 for exactly this cycle; next state is IDLE.
//     No arbitration happens in RESP, so there is a minimum of one IDLE cycle between grants.
//   - Flush: flush_in=1 while owner==IF in BUSY or RESP sets a kill flag.
//     The memory transaction still completes, since the controller cannot abort.
//     if_done is suppressed; rd_data is still updated. The kill flag clears on return to IDLE.
//   - flush_in has no effect on LD/ST.
//   - A requester dropping valid or changing addr/data mid-transaction does not affect the
//     latched transaction; its done still pulses.
//   - Load/store ordering and address hazards are the LSU's responsibility.
//   - At most one *_done is high in any cycle. mc_valid is never high in IDLE or RESP.
//   - rdy_in=0: no state, counter or output changes; mc_ready is ignored that cycle.
// TESTING
//   1. Reset: rst_n_in=0 mid-BUSY -> mc_valid=0, all done=0 immediately;
//      after release, the first LD request is granted with 1-cycle latency.
//   2. Single load: ld_valid, ld_addr=0x100; mc_ready with mc_res=0xDEADBEEF 5 cycles after grant
//      -> mc_addr=0x100, mc_wr=0; ld_done pulses one cycle later with rd_data=0xDEADBEEF.
//   3. LD+ST+IF held continuously, STARVE_LIMIT=4
//      -> grant order LD,ST,LD,ST,IF,LD,...; st grant has mc_wr=1 and mc_wdata=st_data.
//   4. Flush: IF granted at 0x40, flush_in pulsed in BUSY -> transaction completes;
//      if_done stays 0; the next IF request to 0x80 is granted normally.
//   5. rdy_in=0 for 3 cycles with mc_ready=1 during BUSY -> no transition;
//      completes on the first rdy_in=1 cycle with mc_ready=1.
//   6. Store then IF in the same cycle -> ST first, IF next; st_done and if_done never overlap.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the three requester handshakes (IF, LD, ST), the shared read-result
//   bus and the memory-controller request port used by mem_arbiter.
//   Modports:
//     master : arbiter view. It takes requests and controller completions and
//              drives the done pulses, rd_data and the mc_* request.
//     slave  : environment view (front ends + memory controller), the mirror
//              image of master.
//   Signals:
//     if_valid/if_addr/if_done           instruction-fetch requester
//     ld_valid/ld_addr/ld_done           data-load requester
//     st_valid/st_addr/st_data/st_done   data-store requester
//     rd_data                            result of the last read transaction
//     mc_valid/mc_addr/mc_wdata/mc_wr    request to the memory controller
//     mc_ready/mc_res                    completion and read data from controller
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          if_valid;
   logic [AW-1:0] if_addr;
   logic          if_done;

   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic          ld_done;

   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic          st_done;

   logic [DW-1:0] rd_data;

   logic          mc_valid;
   logic [AW-1:0] mc_addr;
   logic [DW-1:0] mc_wdata;
   logic          mc_wr;
   logic          mc_ready;
   logic [DW-1:0] mc_res;

   modport master (
      input  if_valid, if_addr,
      input  ld_valid, ld_addr,
      input  st_valid, st_addr, st_data,
      input  mc_ready, mc_res,
      output if_done, ld_done, st_done,
      output rd_data,
      output mc_valid, mc_addr, mc_wdata, mc_wr
   );

   modport slave (
      output if_valid, if_addr,
      output ld_valid, ld_addr,
      output st_valid, st_addr, st_data,
      output mc_ready, mc_res,
      input  if_done, ld_done, st_done,
      input  rd_data,
      input  mc_valid, mc_addr, mc_wdata, mc_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single word-wide memory-controller request port between
//   instruction fetch (IF), data load (LD) and data store (ST).
//   Data ports have priority over IF and alternate between LD and ST. A
//   starvation counter forces an IF grant after STARVE_LIMIT consecutive data
//   grants while IF was waiting. Only one transaction is in flight; its
//   address and data are latched at grant.
//   Ports:
//     clk_in    system clock
//     rst_n_in  asynchronous active-low reset
//     rdy_in    global ready; low freezes every register
//     flush_in  pipeline flush; blocks a new IF grant and kills an IF in flight
//     bus       mem_arbiter_if.master (requesters, rd_data, controller port)
//   Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic           clk_in,
   input  logic           rst_n_in,
   input  logic           rdy_in,
   input  logic           flush_in,
   mem_arbiter_if.master  bus
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_IF = 2'd0,
      OWN_LD = 2'd1,
      OWN_ST = 2'd2
   } owner_t;

   state_t        state_q,      state_d;
   owner_t        owner_q,      owner_d;
   logic          kill_q,       kill_d;
   logic          last_st_q,    last_st_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;

   logic          mc_valid_q,   mc_valid_d;
   logic [AW-1:0] mc_addr_q,    mc_addr_d;
   logic [DW-1:0] mc_wdata_q,   mc_wdata_d;
   logic          mc_wr_q,      mc_wr_d;
   logic [DW-1:0] rd_data_q,    rd_data_d;
   logic          if_done_q,    if_done_d;
   logic          ld_done_q,    ld_done_d;
   logic          st_done_q,    st_done_d;

   logic          if_req_c;
   logic          starved_c;
   logic          gnt_if_c;
   logic          gnt_ld_c;
   logic          gnt_st_c;
   logic          gnt_any_c;

   // Arbitration over this cycle's requests (only acted on in IDLE).
   always_comb begin
      gnt_if_c  = 1'b0;
      gnt_ld_c  = 1'b0;
      gnt_st_c  = 1'b0;
      // A fetch that is being flushed this very cycle is already stale.
      if_req_c  = bus.if_valid && !flush_in;
      starved_c = (starve_cnt_q == CW'(STARVE_LIMIT));

      if (if_req_c && starved_c) begin
         gnt_if_c = 1'b1;
      end else if (bus.ld_valid && bus.st_valid) begin
         // Both data ports waiting: serve the one that did not go last.
         gnt_ld_c = last_st_q;
         gnt_st_c = !last_st_q;
      end else if (bus.ld_valid) begin
         gnt_ld_c = 1'b1;
      end else if (bus.st_valid) begin
         gnt_st_c = 1'b1;
      end else if (if_req_c) begin
         gnt_if_c = 1'b1;
      end
      gnt_any_c = gnt_if_c || gnt_ld_c || gnt_st_c;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      kill_d       = kill_q;
      last_st_d    = last_st_q;
      starve_cnt_d = starve_cnt_q;
      mc_valid_d   = mc_valid_q;
      mc_addr_d    = mc_addr_q;
      mc_wdata_d   = mc_wdata_q;
      mc_wr_d      = mc_wr_q;
      rd_data_d    = rd_data_q;
      if_done_d    = if_done_q;
      ld_done_d    = ld_done_q;
      st_done_d    = st_done_q;

      // With rdy_in low everything simply holds its value.
      if (rdy_in) begin
         unique case (state_q)
            S_IDLE: begin
               if (!bus.if_valid || gnt_if_c) begin
                  starve_cnt_d = '0;
               end else if ((gnt_ld_c || gnt_st_c) && !starved_c) begin
                  starve_cnt_d = starve_cnt_q + CW'(1);
               end

               if (gnt_any_c) begin
                  state_d    = S_BUSY;
                  mc_valid_d = 1'b1;
                  mc_wr_d    = gnt_st_c;
                  mc_wdata_d = gnt_st_c ? bus.st_data : '0;
                  if (gnt_if_c) begin
                     owner_d   = OWN_IF;
                     mc_addr_d = bus.if_addr;
                  end else if (gnt_ld_c) begin
                     owner_d   = OWN_LD;
                     mc_addr_d = bus.ld_addr;
                     last_st_d = 1'b0;
                  end else begin
                     owner_d   = OWN_ST;
                     mc_addr_d = bus.st_addr;
                     last_st_d = 1'b1;
                  end
               end
            end

            S_BUSY: begin
               if (flush_in && owner_q == OWN_IF) begin
                  kill_d = 1'b1;
               end
               // The controller cannot abort, so a killed fetch still
               // completes and still updates rd_data; only if_done is lost.
               if (bus.mc_ready) begin
                  state_d    = S_RESP;
                  mc_valid_d = 1'b0;
                  if (!mc_wr_q) begin
                     rd_data_d = bus.mc_res;
                  end
                  unique case (owner_q)
                     OWN_IF:  if_done_d = !(kill_q || flush_in);
                     OWN_LD:  ld_done_d = 1'b1;
                     OWN_ST:  st_done_d = 1'b1;
                     default: ;
                  endcase
               end
            end

            S_RESP: begin
               state_d   = S_IDLE;
               kill_d    = 1'b0;
               if_done_d = 1'b0;
               ld_done_d = 1'b0;
               st_done_d = 1'b0;
            end

            default: begin
               state_d    = S_IDLE;
               kill_d     = 1'b0;
               mc_valid_d = 1'b0;
               if_done_d  = 1'b0;
               ld_done_d  = 1'b0;
               st_done_d  = 1'b0;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         kill_q       <= 1'b0;
         last_st_q    <= 1'b1;
         starve_cnt_q <= '0;
         mc_valid_q   <= 1'b0;
         mc_addr_q    <= '0;
         mc_wdata_q   <= '0;
         mc_wr_q      <= 1'b0;
         rd_data_q    <= '0;
         if_done_q    <= 1'b0;
         ld_done_q    <= 1'b0;
         st_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         kill_q       <= kill_d;
         last_st_q    <= last_st_d;
         starve_cnt_q <= starve_cnt_d;
         mc_valid_q   <= mc_valid_d;
         mc_addr_q    <= mc_addr_d;
         mc_wdata_q   <= mc_wdata_d;
         mc_wr_q      <= mc_wr_d;
         rd_data_q    <= rd_data_d;
         if_done_q    <= if_done_d;
         ld_done_q    <= ld_done_d;
         st_done_q    <= st_done_d;
      end
   end

   assign bus.mc_valid = mc_valid_q;
   assign bus.mc_addr  = mc_addr_q;
   assign bus.mc_wdata = mc_wdata_q;
   assign bus.mc_wr    = mc_wr_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.if_done  = if_done_q;
   assign bus.ld_done  = ld_done_q;
   assign bus.st_done  = st_done_q;

   // Structural invariants of the handshake.
   a_done_onehot: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      $onehot0({if_done_q, ld_done_q, st_done_q}));
   a_valid_busy: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      mc_valid_q |-> (state_q == S_BUSY));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   localparam int unsigned STARVE_LIMIT = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
   } grant_t;

   typedef struct packed {
      logic [1:0]  kind;   // 0 IF, 1 LD, 2 ST
      logic [31:0] data;
   } done_t;

   logic clk_in = 1'b0;
   logic rst_n_in;
   logic rdy_in;
   logic flush_in;

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   grant_t      exp_grant_q[$];
   done_t       exp_done_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rd = 32'h0;
   logic        prev_mc_valid = 1'b0;

   function automatic logic [31:0] mem_res(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_inputs();
      rdy_in       = 1'b1;
      flush_in     = 1'b0;
      bus.if_valid = 1'b0;
      bus.if_addr  = '0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.st_valid = 1'b0;
      bus.st_addr  = '0;
      bus.st_data  = '0;
      bus.mc_ready = 1'b0;
      bus.mc_res   = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n_in = 1'b0;
      tick();
      tick();
      rst_n_in = 1'b1;
      last_rd  = 32'h0;
      tick();
   endtask

   // Bounded wait for the next grant; an expired bound is a failure.
   task automatic wait_grant();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.mc_valid !== 1'b1 && n < 20);
      checks++;
      if (bus.mc_valid !== 1'b1) begin
         errors++;
         $display("FAIL grant_timeout: mc_valid=%b after %0d cycles, required 1", bus.mc_valid, n);
      end
   endtask

   // Memory-controller completion after 'delay' BUSY cycles.
   task automatic serve(input int delay, input logic [31:0] res);
      repeat (delay) tick();
      bus.mc_ready = 1'b1;
      bus.mc_res   = res;
      tick();
      bus.mc_ready = 1'b0;
      bus.mc_res   = '0;
   endtask

   // Scoreboard: pops expected grants/done pulses as the DUT produces them.
   task automatic monitor();
      logic [2:0] d;
      grant_t     g_exp;
      grant_t     g_got;
      done_t      r_exp;
      done_t      r_got;
      forever begin
         @(negedge clk_in);
         if (rst_n_in === 1'b1) begin
            d = {bus.st_done, bus.ld_done, bus.if_done};
            checks++;
            if ($countones(d) > 1 || (bus.mc_valid === 1'b1 && d != 3'b000)) begin
               errors++;
               $display("FAIL done_exclusive: dones=%b mc_valid=%b, required at most one done and no mc_valid with done",
                        d, bus.mc_valid);
            end
            if (bus.mc_valid === 1'b1 && prev_mc_valid !== 1'b1) begin
               checks++;
               g_got = {bus.mc_addr, bus.mc_wdata, bus.mc_wr};
               if (exp_grant_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_grant: addr=%h wr=%b, required no grant", bus.mc_addr, bus.mc_wr);
               end else begin
                  g_exp = exp_grant_q.pop_front();
                  if (g_got !== g_exp) begin
                     errors++;
                     $display("FAIL grant: got addr=%h wdata=%h wr=%b, required addr=%h wdata=%h wr=%b",
                              g_got.addr, g_got.wdata, g_got.wr, g_exp.addr, g_exp.wdata, g_exp.wr);
                  end
               end
            end
            if (d != 3'b000) begin
               checks++;
               r_got.kind = d[0] ? 2'd0 : (d[1] ? 2'd1 : 2'd2);
               r_got.data = bus.rd_data;
               if (exp_done_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done: kind=%0d rd_data=%h, required no done", r_got.kind, r_got.data);
               end else begin
                  r_exp = exp_done_q.pop_front();
                  if (r_got !== r_exp) begin
                     errors++;
                     $display("FAIL done: got kind=%0d rd_data=%h, required kind=%0d rd_data=%h",
                              r_got.kind, r_got.data, r_exp.kind, r_exp.data);
                  end
               end
            end
            prev_mc_valid = bus.mc_valid;
         end else begin
            prev_mc_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n_in = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.mc_valid, bus.mc_wr, bus.if_done, bus.ld_done, bus.st_done} !== 5'b0 ||
          bus.mc_addr !== 32'h0 || bus.mc_wdata !== 32'h0 || bus.rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: mc_valid=%b mc_addr=%h rd_data=%h, required all zero",
                  bus.mc_valid, bus.mc_addr, bus.rd_data);
      end
      rst_n_in = 1'b1;
      tick();
      // Grant, then reset in the middle of BUSY (before the monitor samples).
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h10;
      tick();
      checks++;
      if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h10) begin
         errors++;
         $display("FAIL pre_reset_grant: mc_valid=%b mc_addr=%h, required 1 / 00000010", bus.mc_valid, bus.mc_addr);
      end
      #2 rst_n_in = 1'b0;
      #1;
      checks++;
      if (bus.mc_valid !== 1'b0 || {bus.if_done, bus.ld_done, bus.st_done} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset: mc_valid=%b dones=%b, required 0 / 000",
                  bus.mc_valid, {bus.st_done, bus.ld_done, bus.if_done});
      end
      tick();
      rst_n_in    = 1'b1;
      bus.ld_addr = 32'h20;
      exp_grant_q.push_back('{addr: 32'h20, wdata: 32'h0, wr: 1'b0});
      exp_done_q.push_back('{kind: 2'd1, data: mem_res(32'h20)});
      tick();
      checks++;
      if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h20) begin
         errors++;
         $display("FAIL post_reset_latency: mc_valid=%b mc_addr=%h, required 1 / 00000020", bus.mc_valid, bus.mc_addr);
      end
      bus.ld_valid = 1'b0;
      serve(2, mem_res(32'h20));
      last_rd = mem_res(32'h20);
      tick();
   endtask

   task automatic test_single_load();
      exp_grant_q.push_back('{addr: 32'h100, wdata: 32'h0, wr: 1'b0});
      exp_done_q.push_back('{kind: 2'd1, data: 32'hDEAD_BEEF});
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h100;
      tick();
      checks++;
      if (bus.mc_valid !== 1'b1 || bus.mc_wr !== 1'b0 || bus.mc_addr !== 32'h100) begin
         errors++;
         $display("FAIL load_grant: mc_valid=%b mc_wr=%b mc_addr=%h, required 1 / 0 / 00000100",
                  bus.mc_valid, bus.mc_wr, bus.mc_addr);
      end
      bus.ld_valid = 1'b0;
      bus.ld_addr  = 32'hFFFF_FFFF;   // must not disturb the latched address
      serve(4, 32'hDEAD_BEEF);
      checks++;
      if (bus.ld_done !== 1'b1 || bus.rd_data !== 32'hDEAD_BEEF || bus.mc_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_done: ld_done=%b rd_data=%h mc_valid=%b, required 1 / deadbeef / 0",
                  bus.ld_done, bus.rd_data, bus.mc_valid);
      end
      last_rd = 32'hDEAD_BEEF;
      tick();
      checks++;
      if (bus.ld_done !== 1'b0) begin
         errors++;
         $display("FAIL load_done_pulse: ld_done=%b, required 0", bus.ld_done);
      end
   endtask

   task automatic test_priority_starve();
      logic [1:0]  order [6];
      logic [31:0] a;
      order = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1};
      do_reset();
      bus.if_addr  = 32'h200;
      bus.ld_addr  = 32'h300;
      bus.st_addr  = 32'h400;
      bus.st_data  = 32'h5555_AAAA;
      bus.if_valid = 1'b1;
      bus.ld_valid = 1'b1;
      bus.st_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a = (order[i] == 2'd0) ? 32'h200 : ((order[i] == 2'd1) ? 32'h300 : 32'h400);
         if (order[i] == 2'd2) begin
            exp_grant_q.push_back('{addr: a, wdata: 32'h5555_AAAA, wr: 1'b1});
            exp_done_q.push_back('{kind: 2'd2, data: last_rd});
         end else begin
            exp_grant_q.push_back('{addr: a, wdata: 32'h0, wr: 1'b0});
            exp_done_q.push_back('{kind: order[i], data: mem_res(a)});
         end
         wait_grant();
         checks++;
         if (bus.mc_addr !== a || bus.mc_wr !== (order[i] == 2'd2)) begin
            errors++;
            $display("FAIL grant_order[%0d]: mc_addr=%h mc_wr=%b, required %h / %b",
                     i, bus.mc_addr, bus.mc_wr, a, (order[i] == 2'd2));
         end
         if (order[i] == 2'd2) begin
            serve(1, 32'hBAD0_BAD0);
         end else begin
            serve(1, mem_res(a));
            last_rd = mem_res(a);
         end
      end
      bus.if_valid = 1'b0;
      bus.ld_valid = 1'b0;
      bus.st_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_flush();
      // Fetch presented together with a flush is not granted.
      bus.if_valid = 1'b1;
      bus.if_addr  = 32'h40;
      flush_in     = 1'b1;
      tick();
      checks++;
      if (bus.mc_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_blocks_grant: mc_valid=%b, required 0", bus.mc_valid);
      end
      flush_in = 1'b0;
      exp_grant_q.push_back('{addr: 32'h40, wdata: 32'h0, wr: 1'b0});
      tick();
      checks++;
      if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h40) begin
         errors++;
         $display("FAIL if_grant: mc_valid=%b mc_addr=%h, required 1 / 00000040", bus.mc_valid, bus.mc_addr);
      end
      bus.if_valid = 1'b0;
      tick();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      serve(1, mem_res(32'h40));
      last_rd = mem_res(32'h40);
      checks++;
      if (bus.if_done !== 1'b0 || bus.rd_data !== mem_res(32'h40) || bus.mc_valid !== 1'b0) begin
         errors++;
         $display("FAIL flushed_if: if_done=%b rd_data=%h mc_valid=%b, required 0 / %h / 0",
                  bus.if_done, bus.rd_data, bus.mc_valid, mem_res(32'h40));
      end
      tick();
      exp_grant_q.push_back('{addr: 32'h80, wdata: 32'h0, wr: 1'b0});
      exp_done_q.push_back('{kind: 2'd0, data: mem_res(32'h80)});
      bus.if_valid = 1'b1;
      bus.if_addr  = 32'h80;
      tick();
      bus.if_valid = 1'b0;
      serve(2, mem_res(32'h80));
      last_rd = mem_res(32'h80);
      checks++;
      if (bus.if_done !== 1'b1 || bus.rd_data !== mem_res(32'h80)) begin
         errors++;
         $display("FAIL if_after_flush: if_done=%b rd_data=%h, required 1 / %h",
                  bus.if_done, bus.rd_data, mem_res(32'h80));
      end
      tick();
   endtask

   task automatic test_rdy_freeze();
      exp_grant_q.push_back('{addr: 32'h500, wdata: 32'h0, wr: 1'b0});
      exp_done_q.push_back('{kind: 2'd1, data: mem_res(32'h500)});
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h500;
      tick();
      bus.ld_valid = 1'b0;
      rdy_in       = 1'b0;
      bus.mc_ready = 1'b1;
      bus.mc_res   = mem_res(32'h500);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.mc_valid !== 1'b1 || bus.ld_done !== 1'b0 || bus.rd_data !== last_rd) begin
            errors++;
            $display("FAIL rdy_freeze[%0d]: mc_valid=%b ld_done=%b rd_data=%h, required 1 / 0 / %h",
                     i, bus.mc_valid, bus.ld_done, bus.rd_data, last_rd);
         end
      end
      rdy_in = 1'b1;
      tick();
      bus.mc_ready = 1'b0;
      bus.mc_res   = '0;
      last_rd      = mem_res(32'h500);
      checks++;
      if (bus.ld_done !== 1'b1 || bus.mc_valid !== 1'b0 || bus.rd_data !== last_rd) begin
         errors++;
         $display("FAIL rdy_resume: ld_done=%b mc_valid=%b rd_data=%h, required 1 / 0 / %h",
                  bus.ld_done, bus.mc_valid, bus.rd_data, last_rd);
      end
      tick();
   endtask

   task automatic test_store_then_if();
      exp_grant_q.push_back('{addr: 32'h600, wdata: 32'h1234_5678, wr: 1'b1});
      exp_done_q.push_back('{kind: 2'd2, data: last_rd});
      exp_grant_q.push_back('{addr: 32'h700, wdata: 32'h0, wr: 1'b0});
      exp_done_q.push_back('{kind: 2'd0, data: mem_res(32'h700)});
      bus.st_valid = 1'b1;
      bus.st_addr  = 32'h600;
      bus.st_data  = 32'h1234_5678;
      bus.if_valid = 1'b1;
      bus.if_addr  = 32'h700;
      wait_grant();
      checks++;
      if (bus.mc_wr !== 1'b1 || bus.mc_addr !== 32'h600 || bus.mc_wdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL store_first: mc_wr=%b mc_addr=%h mc_wdata=%h, required 1 / 00000600 / 12345678",
                  bus.mc_wr, bus.mc_addr, bus.mc_wdata);
      end
      bus.st_data = 32'h0;   // changing data after grant must not matter
      serve(1, 32'hFFFF_0000);
      bus.st_valid = 1'b0;
      checks++;
      if (bus.st_done !== 1'b1 || bus.if_done !== 1'b0 || bus.rd_data !== last_rd) begin
         errors++;
         $display("FAIL store_done: st_done=%b if_done=%b rd_data=%h, required 1 / 0 / %h",
                  bus.st_done, bus.if_done, bus.rd_data, last_rd);
      end
      wait_grant();
      checks++;
      if (bus.mc_wr !== 1'b0 || bus.mc_addr !== 32'h700 || bus.mc_wdata !== 32'h0) begin
         errors++;
         $display("FAIL if_second: mc_wr=%b mc_addr=%h mc_wdata=%h, required 0 / 00000700 / 0",
                  bus.mc_wr, bus.mc_addr, bus.mc_wdata);
      end
      bus.if_valid = 1'b0;
      serve(1, mem_res(32'h700));
      last_rd = mem_res(32'h700);
      checks++;
      if (bus.if_done !== 1'b1 || bus.st_done !== 1'b0) begin
         errors++;
         $display("FAIL if_done_second: if_done=%b st_done=%b, required 1 / 0", bus.if_done, bus.st_done);
      end
      tick();
      tick();
   endtask

   task automatic test_drain();
      checks++;
      if (exp_grant_q.size() != 0 || exp_done_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d grants and %0d dones left, required 0 and 0",
                  exp_grant_q.size(), exp_done_q.size());
      end
   endtask

   task automatic run_tests();
      test_reset();
      test_single_load();
      test_priority_starve();
      test_flush();
      test_rdy_freeze();
      test_store_then_if();
      test_drain();
   endtask

   initial begin
      clear_inputs();
      rst_n_in = 1'b0;
      fork
         run_tests();
         monitor();
      join_any
      disable fork;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
